// File: rtl/imem_loader.sv
// Purpose : byte-stream loader that fills the instruction RAM and then serves fetch reads by PC.
// Latency : one RAM write per 4 accepted bytes; fetch read port is combinational (0 cycles).
// Backpress: in_ready is registered and high only in LOAD; no timeout, a stalled stream holds all state.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   load_start, load_len     single-cycle load request and word count (1..DEPTH)
//   in_valid/in_byte/in_ready byte stream, little-endian 32-bit words
//   pc, inst                 fetch read port; inst is 0 (nop) unless running
//   core_rst_n, busy, done   core reset (released in RUN), LOAD and RUN indicators
//   err                      sticky error, cleared by the next accepted load_start
// Optional: define LOADER_CHECKSUM_EN to require a 4-byte sum trailer after the data words.
module imem_loader #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    output logic              in_ready,
    input  logic [31:0]       pc,
    output logic [31:0]       inst,
    output logic              core_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int LEN_W = ADDR_W + 1;
    localparam logic [ADDR_W:0] LEN_MAX = LEN_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t          state, state_nxt;
    logic [ADDR_W:0] len;
    logic [ADDR_W:0] word_addr;
    logic [1:0]      byte_idx;
    logic [23:0]     asm_q;     // byte 3 never needs storing, it completes the word directly
    logic [31:0]     ram [DEPTH];

    logic            len_ok, start_ok, xfer, word_done, last_data, ram_we;
    logic [31:0]     word;
    logic            in_ready_d, busy_d, done_d, core_rst_n_d, err_d;
    logic            unused_sig;

    assign len_ok    = (load_len != '0) && (load_len <= LEN_MAX);
    // load_start is ignored while a load is in progress
    assign start_ok  = load_start && len_ok && (state != LOAD);
    assign xfer      = in_valid && in_ready;
    assign word_done = xfer && (byte_idx == 2'd3);
    assign word      = {in_byte, asm_q};
    assign last_data = (word_addr == len - LEN_W'(1));

`ifdef LOADER_CHECKSUM_EN
    logic [31:0] sum;
    logic        trailer;
    // word_addr runs one past the data words while the trailer is assembled
    assign trailer = (word_addr == len);
    assign ram_we  = word_done && !trailer;
    assign unused_sig = ^{pc[31:ADDR_W+2], pc[1:0], last_data};
`else
    assign ram_we  = word_done;
    assign unused_sig = ^{pc[31:ADDR_W+2], pc[1:0]};
`endif

    // State register; handshake/status outputs are registered alongside it so they
    // switch on exactly the edge the state changes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            core_rst_n <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            in_ready   <= in_ready_d;
            busy       <= busy_d;
            done       <= done_d;
            core_rst_n <= core_rst_n_d;
            err        <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_ok) state_nxt = LOAD;
            LOAD: begin
`ifdef LOADER_CHECKSUM_EN
                if (word_done && trailer)
                    state_nxt = (word == sum) ? RUN : IDLE;
`else
                if (word_done && last_data)
                    state_nxt = RUN;
`endif
            end
            RUN:  if (start_ok) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic, computed from the next state so the registered copies line up with it
    always_comb begin
        in_ready_d   = (state_nxt == LOAD);
        busy_d       = (state_nxt == LOAD);
        done_d       = (state_nxt == RUN);
        core_rst_n_d = (state_nxt == RUN);
        err_d        = err;
        if (load_start && (state != LOAD))
            err_d = !len_ok;
`ifdef LOADER_CHECKSUM_EN
        if ((state == LOAD) && word_done && trailer && (word != sum))
            err_d = 1'b1;
`endif
    end

    // Word assembly and address counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            len       <= '0;
            word_addr <= '0;
            byte_idx  <= '0;
            asm_q     <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum       <= '0;
`endif
        end else if (start_ok) begin
            len       <= load_len;
            word_addr <= '0;
            byte_idx  <= '0;
            asm_q     <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum       <= '0;
`endif
        end else if (xfer) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
                2'd0: asm_q[7:0]   <= in_byte;
                2'd1: asm_q[15:8]  <= in_byte;
                2'd2: asm_q[23:16] <= in_byte;
                default: begin
                    asm_q     <= '0;
                    word_addr <= word_addr + LEN_W'(1);
`ifdef LOADER_CHECKSUM_EN
                    if (!trailer)
                        sum <= sum + word;
`endif
                end
            endcase
        end
    end

    // RAM has no reset: loaded words survive a reset. A write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (rst && ram_we)
            ram[word_addr[ADDR_W-1:0]] <= word;
    end

    // Upper pc bits truncate (wrap); pc[1:0] ignored
    assign inst = (state == RUN) ? ram[pc[ADDR_W+1:2]] : 32'h0000_0000;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              load_start = 1'b0;
    logic [ADDR_W:0]   load_len = '0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_byte = '0;
    logic              in_ready;
    logic [31:0]       pc = '0;
    logic [31:0]       inst;
    logic              core_rst_n, busy, done, err;

    int checks = 0;
    int errors = 0;

    logic [31:0] load_q [$];      // words of the next load
    logic [31:0] exp_q  [$];      // scoreboard of expected fetch reads
    logic [31:0] model  [DEPTH];  // reference copy of RAM

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .load_len   (load_len),
        .in_valid   (in_valid),
        .in_byte    (in_byte),
        .in_ready   (in_ready),
        .pc         (pc),
        .inst       (inst),
        .core_rst_n (core_rst_n),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // All tasks start and end 1 time unit after a rising edge.
    task automatic start_load(input logic [ADDR_W:0] len);
        load_start = 1'b1;
        load_len   = len;
        @(posedge clk); #1;
        load_start = 1'b0;
    endtask

    // Present one byte and wait (bounded) for the edge that takes it
    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_byte  = b;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL byte_accept_timeout byte=%h in_ready=%b required 1", b, in_ready);
        end
    endtask

    task automatic load_words(input bit throttle, input bit bad_trailer);
        logic [31:0] sum;
        logic [31:0] w;
        sum = '0;
        for (int i = 0; i < load_q.size(); i++) begin
            w = load_q[i];
            for (int k = 0; k < 4; k++) begin
                send_byte(w[8*k +: 8]);
                if (throttle) begin
                    in_valid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            model[i] = w;
            sum += w;
        end
`ifdef LOADER_CHECKSUM_EN
        w = bad_trailer ? sum + 32'd1 : sum;
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
`endif
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0)   begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        checks++; if (core_rst_n !== 1'b0) begin errors++; $display("FAIL reset_core_rst_n got %b exp 0", core_rst_n); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0)       begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (err !== 1'b0)        begin errors++; $display("FAIL reset_err got %b exp 0", err); end
        for (int i = 0; i < 4; i++) begin
            pc = $urandom; #1;
            checks++;
            if (inst !== 32'h0) begin errors++; $display("FAIL reset_inst pc=%h got %h exp 00000000", pc, inst); end
        end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_load();
        load_q = '{32'h00500113, 32'h00210233};
        start_load(2);
        checks++; if (busy !== 1'b1 || in_ready !== 1'b1 || core_rst_n !== 1'b0) begin
            errors++; $display("FAIL basic_enter_load busy=%b in_ready=%b core_rst_n=%b exp 1 1 0", busy, in_ready, core_rst_n);
        end
        load_words(1'b0, 1'b0);
        checks++; if (done !== 1'b1 || core_rst_n !== 1'b1) begin
            errors++; $display("FAIL basic_run done=%b core_rst_n=%b exp 1 1", done, core_rst_n);
        end
        checks++; if (in_ready !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_ready_drop in_ready=%b busy=%b exp 0 0", in_ready, busy);
        end
        pc = 32'd4; #1;
        checks++; if (inst !== 32'h00210233) begin errors++; $display("FAIL basic_inst_pc4 got %h exp 00210233", inst); end
        for (int i = 0; i < 2; i++) exp_q.push_back(model[i]);
        for (int i = 0; i < 2; i++) begin
            logic [31:0] e;
            pc = 32'(i * 4) + 32'($urandom_range(0, 3)); #1;
            e = exp_q.pop_front();
            checks++;
            if (inst !== e) begin errors++; $display("FAIL basic_ram[%0d] got %h exp %h", i, inst, e); end
        end
    endtask

    task automatic test_throttled();
        load_q = '{32'h00500113, 32'h00210233};
        start_load(2);
        checks++; if (done !== 1'b0 || core_rst_n !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL throttle_leave_run done=%b core_rst_n=%b busy=%b exp 0 0 1", done, core_rst_n, busy);
        end
        load_words(1'b1, 1'b0);
        checks++; if (in_ready !== 1'b0 || done !== 1'b1) begin
            errors++; $display("FAIL throttle_end in_ready=%b done=%b exp 0 1", in_ready, done);
        end
        for (int i = 0; i < 2; i++) exp_q.push_back(model[i]);
        for (int i = 0; i < 2; i++) begin
            logic [31:0] e;
            pc = 32'(i * 4); #1;
            e = exp_q.pop_front();
            checks++;
            if (inst !== e) begin errors++; $display("FAIL throttle_ram[%0d] got %h exp %h", i, inst, e); end
        end
    endtask

    task automatic test_illegal_len();
        start_load(0);
        checks++; if (err !== 1'b1 || done !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL illegal_len0 err=%b done=%b in_ready=%b exp 1 1 0", err, done, in_ready);
        end
        start_load(DEPTH + 1);
        checks++; if (err !== 1'b1 || done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL illegal_len33 err=%b done=%b busy=%b in_ready=%b exp 1 1 0 0", err, done, busy, in_ready);
        end
        pc = 32'd0; #1;
        checks++; if (inst !== model[0]) begin errors++; $display("FAIL illegal_inst got %h exp %h", inst, model[0]); end
    endtask

    task automatic test_full_depth();
        load_q.delete();
        for (int i = 0; i < DEPTH; i++) load_q.push_back($urandom);
        start_load(DEPTH);
        checks++; if (err !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL full_start err=%b busy=%b exp 0 1", err, busy);
        end
        load_words(1'b0, 1'b0);
        checks++; if (done !== 1'b1 || core_rst_n !== 1'b1) begin
            errors++; $display("FAIL full_run done=%b core_rst_n=%b exp 1 1", done, core_rst_n);
        end
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(model[i]);
        for (int i = 0; i < DEPTH; i++) begin
            logic [31:0] e;
            // random high bits exercise address wrap
            pc = ($urandom & 32'hFFFF_FF80) | 32'(i << 2) | 32'($urandom_range(0, 3)); #1;
            e = exp_q.pop_front();
            checks++;
            if (inst !== e) begin errors++; $display("FAIL full_ram[%0d] pc=%h got %h exp %h", i, pc, inst, e); end
        end
    endtask

    task automatic test_reset_mid_load();
        logic [31:0] w;
        w = 32'h00500113;
        start_load(2);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
        model[0] = w;
        send_byte(8'hFF);
        in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        checks++; if (busy !== 1'b0 || in_ready !== 1'b0 || core_rst_n !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL midrst_idle busy=%b in_ready=%b core_rst_n=%b done=%b exp 0 0 0 0", busy, in_ready, core_rst_n, done);
        end
        checks++; if (inst !== 32'h0) begin errors++; $display("FAIL midrst_inst got %h exp 00000000", inst); end
        start_load(DEPTH + 1);
        checks++; if (err !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL midrst_illegal err=%b busy=%b exp 1 0", err, busy);
        end
        load_q = '{32'h00000013};
        start_load(1);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL midrst_err_clear got %b exp 0", err); end
        load_words(1'b0, 1'b0);
        checks++; if (done !== 1'b1 || core_rst_n !== 1'b1) begin
            errors++; $display("FAIL midrst_reload done=%b core_rst_n=%b exp 1 1", done, core_rst_n);
        end
        // word 1 must hold its pre-reset value, not the discarded partial word
        for (int i = 0; i < 2; i++) exp_q.push_back(model[i]);
        for (int i = 0; i < 2; i++) begin
            logic [31:0] e;
            pc = 32'(i * 4); #1;
            e = exp_q.pop_front();
            checks++;
            if (inst !== e) begin errors++; $display("FAIL midrst_ram[%0d] got %h exp %h", i, inst, e); end
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        load_q = '{32'h00000013};
        start_load(1);
        load_words(1'b0, 1'b0);
        checks++; if (done !== 1'b1 || core_rst_n !== 1'b1 || err !== 1'b0) begin
            errors++; $display("FAIL csum_good done=%b core_rst_n=%b err=%b exp 1 1 0", done, core_rst_n, err);
        end
        pc = 32'd0; #1;
        checks++; if (inst !== 32'h00000013) begin errors++; $display("FAIL csum_inst got %h exp 00000013", inst); end
        start_load(1);
        load_words(1'b0, 1'b1);
        checks++; if (err !== 1'b1 || done !== 1'b0 || core_rst_n !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL csum_bad err=%b done=%b core_rst_n=%b busy=%b exp 1 0 0 0", err, done, core_rst_n, busy);
        end
        checks++; if (inst !== 32'h0) begin errors++; $display("FAIL csum_bad_inst got %h exp 00000000", inst); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_load();
        test_throttled();
        test_illegal_len();
        test_full_depth();
        test_reset_mid_load();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Writer side of the instruction-memory interface that fetch reads from.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes those words into an internal instruction RAM.
- Holds the core in reset until the load completes.
- After the load, serves fetch with a combinational read port indexed by PC, replacing the hard-coded initial program.

Parameters:
DEPTH, 32, number of 32-bit instruction words.
ADDR_W, 5, word-address width; must equal log2(DEPTH).

Ports:
clk  input  1  clock, all state updates on posedge.
rst  input  1  reset, synchronous, active-low.
load_start  input  1  single-cycle request to begin a load.
load_len  input  ADDR_W+1  number of words to load; sampled with load_start.
in_valid  input  1  byte-stream valid.
in_byte  input  8  byte-stream data.
in_ready  output  1  byte-stream ready (registered).
pc  input  32  fetch program counter (byte address).
inst  output  32  instruction at pc.
core_rst_n  output  1  active-low reset to the core; registered.
busy  output  1  high in LOAD.
done  output  1  high in RUN.
err  output  1  sticky error flag; cleared by the next accepted load_start.

Behaviour:
Reset (rst=0 at posedge):
- state=IDLE; in_ready=0, core_rst_n=0, busy=0, done=0, err=0.
- word_addr=0, byte_idx=0, len=0, assembly register=0.
- RAM contents are not cleared; words already written survive reset.

FSM states IDLE, LOAD, RUN:
- IDLE:
  - load_start with 1<=load_len<=DEPTH: capture len, clear word_addr/byte_idx/err; next state LOAD, in_ready=1 and busy=1 from the next cycle.
  - load_start with load_len==0 or >DEPTH: err=1, stay IDLE.
- LOAD:
  - A transfer occurs when in_valid & in_ready at posedge. Byte k (k=byte_idx, 0..3) goes to bits [8k+7:8k].
  - On the transfer with byte_idx==3, write {in_byte, asm[23:0]} to RAM[word_addr] on that same edge; then word_addr++ and byte_idx=0.
  - When the written word is word len-1: next state RUN. in_ready and busy drop on that same edge, so no further byte is accepted.
  - in_valid low: hold all state, no timeout.
  - load_start in LOAD: ignored.
- RUN:
  - core_rst_n=1, done=1, in_ready=0; in_valid ignored.
  - load_start with a legal length: LOAD next cycle; core_rst_n=0 and done=0 on that same edge.
  - load_start with an illegal length: err=1, stay RUN.

Fetch read port:
- inst = RAM[pc[ADDR_W+1:2]], combinational; pc[1:0] ignored.
- pc above DEPTH*4 wraps by truncation.
- inst forced to 32'h00000000 (nop) whenever state != RUN.

Other rules:
- core_rst_n is registered and changes on the same edge the state enters or leaves RUN.
- Reset mid-LOAD: return to IDLE. The partial word is discarded; completed words stay in RAM.
- Back-to-back bytes at one per cycle are supported; throughput is 4 cycles per word.

Optional Feature:
Macro LOADER_CHECKSUM_EN.
- Defined:
  - After the last data word, LOAD expects one extra 4-byte trailer word, assembled little-endian.
  - The trailer is not written to RAM; it is compared against the running 32-bit sum (mod 2^32) of all data words.
  - Match: enter RUN.
  - Mismatch: err=1, go to IDLE, core_rst_n stays 0.
  - in_ready stays high through the trailer.
- Undefined: no trailer, no sum register; RUN is entered right after the last data word.

Test Plan:
- Reset check: hold rst=0 for 2 cycles -> in_ready=0, core_rst_n=0, busy=0, done=0, err=0, inst=0 for any pc.
- Basic load: load_len=2, stream 13,01,50,00,33,02,21,00 back-to-back -> RAM[0]=32'h00500113, RAM[1]=32'h00210233. done=1 and core_rst_n=1 on the edge after the 8th byte; inst=32'h00210233 at pc=4.
- Throttled stream: same data with in_valid toggling every other cycle -> identical RAM contents. No byte is lost or duplicated; in_ready=0 immediately after the 8th transfer.
- Illegal length: load_start with load_len=0, and again with DEPTH+1 -> err=1, state unchanged, in_ready stays 0.
- Reset mid-load: reset after 5 bytes of a 2-word load -> IDLE, RAM[0]=32'h00500113 retained, core_rst_n=0. A fresh load then succeeds and clears err.
- Reload and checksum (with LOADER_CHECKSUM_EN):
  - 1-word load of 32'h00000013 with trailer 32'h00000013 -> RUN.
  - Repeat from RUN with trailer 32'h00000014 -> err=1, IDLE, core_rst_n=0.
